// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//
// Bit-serial receiver for the sensor link. It deserialises an asynchronous,
// LSB-first, 8-bit frame into a parallel byte and hands it to the packet logic
// with a one-cycle valid strobe. Bit timing is CLK_PER_BIT system clocks per
// bit, so no separate baud clock is needed.
//
// Frame (default build): start(0), d0..d7, stop(1)             -> 10 bits
// Frame (SERIAL_RX_PARITY_EN defined): start, d0..d7, even parity, stop -> 11 bits
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   defined   : PARITY state exists, parity_err reports even-parity mismatches
//   undefined : no parity bit in the frame, parity_err tied to 0
//
// Parameters
//   CLK_PER_BIT  system-clock cycles per serial bit (legal 4 .. 2^16-1)
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   reset       in   synchronous, active-high; clears all state and outputs
//   enable      in   receiver enable; low abandons any frame and holds IDLE
//   rx          in   serial line, idle high, asynchronous to clk
//   data        out  [7:0] last correctly received byte
//   data_valid  out  one-cycle pulse, data updated on the same edge
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   parity_err  out  one-cycle pulse, parity mismatch (parity build only)
//   busy        out  high whenever the receiver is not IDLE
// -----------------------------------------------------------------------------
module serial_rx #(
  parameter int CLK_PER_BIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT) + 1;

  // Terminal counts. The counter is cleared on the edge that enters a state,
  // so a state that must sample N cycles after entry compares against N-1.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

`ifdef SERIAL_RX_PARITY_EN
  // Even parity: the eight data bits plus the parity bit hold an even number
  // of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ~(^d ^ p);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic [1:0]       sync_q, sync_d;
  logic             rxs;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_q, par_d;
  logic             pe_q, pe_d;
`endif

  // Stage p0/p1: two-flop synchroniser; resets to the idle line level so a
  // reset never looks like a start bit.
  assign sync_d = {sync_q[0], rx};
  assign rxs    = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    if (!enable) begin
      // Abandon any frame without a strobe; the last good byte is kept.
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs;
            if (idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            par_d   = rxs;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (!rxs) begin
              // Framing error wins over parity; wait out a held-low line so
              // a break is not mistaken for the next start bit.
              fe_d    = 1'b1;
              state_d = WAIT_HIGH;
            end else begin
              state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
              if (!parity_ok(shift_q, par_q)) begin
                pe_d = 1'b1;
              end else begin
                data_d = shift_q;
                dv_d   = 1'b1;
              end
`else
              data_d = shift_q;
              dv_d   = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          if (rxs) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      sync_q  <= 2'b11;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      sync_q  <= sync_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
  assign busy       = (state_q != IDLE);

endmodule
